// File: rtl/dwc_array.sv
// Depthwise KxK convolution over ROWS output rows: serial weight load, per-row
// K-column sliding window, stride 1/2, two-stage multiply / adder-tree pipeline.

module dwc_row #(
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cap,
    input  logic                          upd,
    input  logic [K*K-1:0][DATA_W-1:0]    w,
    input  logic [K*K-1:0][DATA_W-1:0]    x,
    output logic [ACC_W-1:0]              sum
);
    localparam int KK = K * K;
    localparam int PW = 2 * DATA_W;

    logic [KK-1:0][PW-1:0] prod, prod_nxt;
    logic [ACC_W-1:0]      acc;

    // Sign-extend both operands to PW so the truncated product is the exact signed product.
    always_comb begin
        prod_nxt = '0;
        for (int n = 0; n < KK; n++)
            prod_nxt[n] = {{DATA_W{w[n][DATA_W-1]}}, w[n]} * {{DATA_W{x[n][DATA_W-1]}}, x[n]};
    end

    always_comb begin
        acc = '0;
        for (int n = 0; n < KK; n++)
            acc = acc + {{(ACC_W-PW){prod[n][PW-1]}}, prod[n]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
            sum  <= '0;
        end else begin
            if (cap) prod <= prod_nxt;
            if (upd) sum  <= acc;
        end
    end
endmodule

module dwc_array #(
    parameter int ROWS   = 4,
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int COL_W  = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            w_load,
    input  logic [DATA_W-1:0]               w_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_first,
    input  logic                            in_stride2,
    input  logic [(ROWS+K-1)*DATA_W-1:0]    in_col,
    output logic                            out_valid,
    output logic [ROWS*ACC_W-1:0]           out_sum,
    output logic [COL_W-1:0]                out_col
);
    localparam int NR     = ROWS + K - 1;
    localparam int KK     = K * K;
    localparam int WC_W   = $clog2(KK + 1);
    localparam int CNT_W  = COL_W + 1;
    localparam int STAGES = 1;

    localparam logic [1:0] W_EMPTY = 2'd0;
    localparam logic [1:0] LOADING = 2'd1;
    localparam logic [1:0] READY   = 2'd2;

    logic [1:0]                          state;
    logic [WC_W-1:0]                     wcnt;
    logic [KK-1:0][DATA_W-1:0]           w;
    logic [NR-1:0][K-1:0][DATA_W-1:0]    win, win_nxt;
    logic [CNT_W-1:0]                    col_cnt, cnt_nxt, cnt_off;
    logic                                col_vld, stride, stride_nxt;
    logic                                xfer, emit, w_last, enter_loading;
    logic [COL_W-1:0]                    col_nxt, col_s1;
    logic [STAGES:0]                     vld_pipe;

    assign in_ready      = (state == READY);
    assign xfer          = in_valid && in_ready;
    assign w_last        = (wcnt == WC_W'(KK - 1));
    assign enter_loading = w_load && !w_last;
    assign out_valid     = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= W_EMPTY;
            wcnt  <= '0;
            w     <= '0;
        end else if (w_load) begin
            w[wcnt] <= w_data;
            if (w_last) begin
                state <= READY;
                wcnt  <= '0;
            end else begin
                state <= LOADING;
                wcnt  <= wcnt + WC_W'(1);
            end
        end
    end

    always_comb begin
        win_nxt = win;
        for (int r = 0; r < NR; r++) begin
            for (int j = 0; j < K - 1; j++)
                win_nxt[r][j] = win[r][j+1];
            win_nxt[r][K-1] = in_col[r*DATA_W +: DATA_W];
        end
    end

    // col_vld low means the next transfer starts a sweep even without in_first.
    always_comb begin
        stride_nxt = in_first ? in_stride2 : stride;
        if (in_first || !col_vld)
            cnt_nxt = '0;
        else if (&col_cnt)
            cnt_nxt = col_cnt;
        else
            cnt_nxt = col_cnt + CNT_W'(1);
        cnt_off = cnt_nxt - CNT_W'(K - 1);
        emit    = xfer && (cnt_nxt >= CNT_W'(K - 1)) && !(stride_nxt && cnt_off[0]);
        col_nxt = stride_nxt ? cnt_off[COL_W:1] : cnt_off[COL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win      <= '0;
            col_cnt  <= '0;
            col_vld  <= 1'b0;
            stride   <= 1'b0;
            vld_pipe <= '0;
            col_s1   <= '0;
            out_col  <= '0;
        end else begin
            if (enter_loading) begin
                col_cnt <= '0;
                col_vld <= 1'b0;
            end else if (xfer) begin
                col_cnt <= cnt_nxt;
                col_vld <= 1'b1;
            end
            if (xfer && in_first) stride <= in_stride2;
            if (xfer)             win    <= win_nxt;
            vld_pipe <= {vld_pipe[STAGES-1:0], emit};
            if (emit)        col_s1  <= col_nxt;
            if (vld_pipe[0]) out_col <= col_s1;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [KK-1:0][DATA_W-1:0] xr;
        for (genvar i = 0; i < K; i++) begin : g_i
            for (genvar j = 0; j < K; j++) begin : g_j
                assign xr[i*K+j] = win_nxt[r+i][j];
            end
        end
        dwc_row #(.K(K), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_row (
            .clk (clk),
            .rst (rst),
            .cap (emit),
            .upd (vld_pipe[0]),
            .w   (w),
            .x   (xr),
            .sum (out_sum[r*ACC_W +: ACC_W])
        );
    end
endmodule

// File: tb/tb_dwc_array.sv
// Directed bench for dwc_array: table-driven column streams plus hand-written
// reload and reset sequences.

module tb_dwc_array;
    localparam int ROWS = 4, K = 3, DATA_W = 8, ACC_W = 32, COL_W = 10;
    localparam int CW = (ROWS + K - 1) * DATA_W;

    logic                   clk = 0;
    logic                   rst, w_load, in_valid, in_ready, in_first, in_stride2, out_valid;
    logic [DATA_W-1:0]      w_data;
    logic [CW-1:0]          in_col;
    logic [ROWS*ACC_W-1:0]  out_sum;
    logic [COL_W-1:0]       out_col;

    dwc_array #(.ROWS(ROWS), .K(K), .DATA_W(DATA_W), .ACC_W(ACC_W), .COL_W(COL_W)) dut (
        .clk(clk), .rst(rst), .w_load(w_load), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_stride2(in_stride2), .in_col(in_col), .out_valid(out_valid),
        .out_sum(out_sum), .out_col(out_col)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              vl, f, s2, ramp;
        logic [31:0]       val;
        logic              ev;
        logic [31:0]       ecol;
        logic [3:0][31:0]  es;
    } vec_t;

    vec_t tv[$];
    int   checks = 0, failures = 0, vn = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic longint row_sum(input int r);
        return longint'($signed(out_sum[r*ACC_W +: ACC_W]));
    endfunction

    function automatic logic [CW-1:0] mkcol(input bit ramp, input int val);
        logic [CW-1:0] c;
        for (int r = 0; r < ROWS + K - 1; r++)
            c[r*DATA_W +: DATA_W] = DATA_W'(ramp ? r * 8 + val : val);
        return c;
    endfunction

    // Closed form for weights 1..9 and x[r][c] = 8r+c, window ending at column c.
    function automatic int rs(input int r, input int c);
        return 360 * r + 45 * c + 465;
    endfunction

    function automatic void addu(input bit vl, input bit f, input bit s2, input int val,
                                 input bit ev, input int ecol, input int es);
        vec_t t;
        t.vl = vl; t.f = f; t.s2 = s2; t.ramp = 1'b0; t.val = val;
        t.ev = ev; t.ecol = ecol;
        for (int r = 0; r < 4; r++) t.es[r] = es;
        tv.push_back(t);
    endfunction

    function automatic void addr(input bit vl, input bit f, input int c,
                                 input bit ev, input int ecol, input int ec);
        vec_t t;
        t.vl = vl; t.f = f; t.s2 = 1'b0; t.ramp = 1'b1; t.val = c;
        t.ev = ev; t.ecol = ecol;
        for (int r = 0; r < 4; r++) t.es[r] = rs(r, ec);
        tv.push_back(t);
    endfunction

    task automatic chk_out(input string tag, input bit ev, input int ecol, input int es0,
                           input int es1, input int es2, input int es3);
        int es[4];
        es = '{es0, es1, es2, es3};
        chk($sformatf("%s out_valid", tag), out_valid, ev);
        if (ev) begin
            chk($sformatf("%s out_col", tag), out_col, ecol);
            for (int r = 0; r < ROWS; r++)
                chk($sformatf("%s sum[%0d]", tag, r), row_sum(r), es[r]);
        end
    endtask

    task automatic run_tab();
        vec_t t;
        while (tv.size() > 0) begin
            t = tv.pop_front();
            vn++;
            w_load = 0; in_valid = t.vl; in_first = t.f; in_stride2 = t.s2;
            in_col = mkcol(t.ramp, int'(t.val));
            step();
            chk_out($sformatf("v%0d", vn), t.ev, int'(t.ecol), int'(t.es[0]), int'(t.es[1]),
                    int'(t.es[2]), int'(t.es[3]));
        end
        in_valid = 0; in_first = 0; in_stride2 = 0;
    endtask

    task automatic load_w(input bit ramp, input int val);
        in_valid = 0;
        for (int n = 0; n < K * K; n++) begin
            w_load = 1;
            w_data = DATA_W'(ramp ? n + 1 : val);
            step();
            if (n == 0) chk("in_ready during load", in_ready, 0);
        end
        w_load = 0;
        chk("in_ready after load", in_ready, 1);
    endtask

    initial begin
        rst = 1; w_load = 0; w_data = 0; in_valid = 0; in_first = 0; in_stride2 = 0; in_col = 0;
        repeat (2) step();
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_col", out_col, 0);
        for (int r = 0; r < ROWS; r++) chk($sformatf("rst sum[%0d]", r), row_sum(r), 0);
        rst = 0;
        step();
        chk("empty in_ready", in_ready, 0);

        // all-ones window
        load_w(0, 1);
        addu(1, 1, 0, 1, 0, 0, 0);
        addu(1, 0, 0, 1, 0, 0, 0);
        addu(1, 0, 0, 1, 0, 0, 0);
        addu(1, 0, 0, 1, 1, 0, 9);
        addu(1, 0, 0, 1, 1, 1, 9);
        addu(0, 0, 0, 1, 1, 2, 9);
        addu(0, 0, 0, 1, 0, 0, 0);
        run_tab();

        // signed extremes
        load_w(0, -128);
        addu(1, 1, 0, -128, 0, 0, 0);
        addu(1, 0, 0, -128, 0, 0, 0);
        addu(1, 0, 0, -128, 0, 0, 0);
        addu(0, 0, 0, 0, 1, 0, 147456);
        addu(0, 0, 0, 0, 0, 0, 0);
        run_tab();
        load_w(0, 127);
        addu(1, 1, 0, -128, 0, 0, 0);
        addu(1, 0, 0, -128, 0, 0, 0);
        addu(1, 0, 0, -128, 0, 0, 0);
        addu(0, 0, 0, 0, 1, 0, -146304);
        addu(0, 0, 0, 0, 0, 0, 0);
        run_tab();

        // stride 2 sweep, then stride 1 sweep (in_stride2 ignored off in_first)
        load_w(0, 1);
        addu(1, 1, 1, 2, 0, 0, 0);
        addu(1, 0, 0, 2, 0, 0, 0);
        addu(1, 0, 0, 2, 0, 0, 0);
        addu(1, 0, 0, 2, 1, 0, 18);
        addu(1, 0, 0, 2, 0, 0, 0);
        addu(1, 0, 0, 2, 1, 1, 18);
        addu(1, 0, 0, 2, 0, 0, 0);
        addu(0, 0, 0, 2, 1, 2, 18);
        addu(1, 1, 0, 2, 0, 0, 0);
        addu(1, 0, 1, 2, 0, 0, 0);
        addu(1, 0, 1, 2, 0, 0, 0);
        addu(0, 0, 0, 2, 1, 0, 18);
        addu(0, 0, 0, 2, 0, 0, 0);
        run_tab();

        // ramp weights and pixels with bubbles carrying junk pixels
        load_w(1, 0);
        addr(1, 1, 0, 0, 0, 0);
        addr(1, 0, 1, 0, 0, 0);
        addu(0, 0, 0, 99, 0, 0, 0);
        addr(1, 0, 2, 0, 0, 0);
        addu(0, 0, 0, 99, 0, 0, 0);
        addu(0, 0, 0, 99, 0, 0, 0);
        tv[tv.size()-2].ev = 1; tv[tv.size()-2].ecol = 0;
        for (int r = 0; r < 4; r++) tv[tv.size()-2].es[r] = rs(r, 2);
        tv.pop_back();
        addr(1, 0, 3, 0, 0, 0);
        addr(1, 0, 4, 1, 1, 3);
        addu(0, 0, 0, 99, 0, 0, 0);
        tv[tv.size()-1].ev = 1; tv[tv.size()-1].ecol = 2;
        for (int r = 0; r < 4; r++) tv[tv.size()-1].es[r] = rs(r, 4);
        addr(1, 0, 5, 0, 0, 0);
        addr(0, 0, 0, 1, 3, 5);
        addu(0, 0, 0, 0, 0, 0, 0);
        run_tab();

        // reload mid-sweep with in_valid held high
        load_w(0, 1);
        in_valid = 1; in_first = 1; in_col = mkcol(0, 1);
        step();
        in_first = 0;
        step();
        step();
        chk("reload pre out_valid", out_valid, 0);
        w_load = 1; w_data = 2;
        step();
        chk_out("reload T3", 1, 0, 9, 9, 9, 9);
        chk("reload in_ready", in_ready, 0);
        in_col = mkcol(0, 3);
        for (int n = 1; n < K * K; n++) begin
            step();
            if (n == 1) chk_out("reload T4 old w", 1, 1, 9, 9, 9, 9);
            else chk($sformatf("reload idle %0d out_valid", n), out_valid, 0);
            if (n < K * K - 1) chk($sformatf("reload %0d in_ready", n), in_ready, 0);
        end
        w_load = 0;
        chk("reload done in_ready", in_ready, 1);
        for (int p = 1; p <= 3; p++) begin
            step();
            chk($sformatf("post-reload P%0d out_valid", p), out_valid, 0);
        end
        in_valid = 0;
        step();
        chk_out("post-reload P3", 1, 0, 54, 54, 54, 54);
        step();
        chk("post-reload drain", out_valid, 0);

        // reset with two results in flight
        in_valid = 1; in_first = 1; in_col = mkcol(0, 1);
        step();
        in_first = 0;
        step(); step(); step();
        chk_out("pre-rst T3", 1, 0, 18, 18, 18, 18);
        rst = 1;
        step();
        chk("rst flight out_valid", out_valid, 0);
        chk("rst flight in_ready", in_ready, 0);
        chk("rst flight sum[0]", row_sum(0), 0);
        step();
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("post-rst %0d out_valid", c), out_valid, 0);
            chk($sformatf("post-rst %0d in_ready", c), in_ready, 0);
        end
        in_valid = 0;
        load_w(0, 1);
        addu(1, 0, 0, 4, 0, 0, 0);
        addu(1, 0, 0, 4, 0, 0, 0);
        addu(1, 0, 0, 4, 0, 0, 0);
        addu(0, 0, 0, 0, 1, 0, 36);
        run_tab();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
